// File: rtl/ca3_assoc_memory_n.sv
`default_nettype none
// ============================================================================
//  Module   : ca3_assoc_memory_n
//  Brief    : N-unit theta-gated CA3 auto-associative memory with Hebbian /
//             anti-Hebbian learning, threshold recall and periodic weight decay.
//  Revision : 1.0  initial release
// ============================================================================
module ca3_assoc_memory_n #(
  parameter int N_UNITS       = 6,
  parameter int WIDTH         = 18,
  parameter int WEIGHT_W      = 8,
  parameter int LR_POT        = 4,
  parameter int LR_DEP        = 2,
  parameter int PEAK_THRESH   = 12288,
  parameter int TROUGH_THRESH = -12288,
  parameter int HYST          = 2000,
  parameter int RECALL_THRESH = 0,
  parameter int DECAY_PERIOD  = 4000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic signed [WIDTH-1:0]     theta_x,
  input  logic [N_UNITS-1:0]          pattern_in,
  input  logic                        pattern_valid,
  input  logic                        learn_enable,
  input  logic                        decay_en,
  input  logic [$clog2(N_UNITS)-1:0]  wt_rd_row,
  input  logic [$clog2(N_UNITS)-1:0]  wt_rd_col,
  output logic [WEIGHT_W-1:0]         wt_rd_data,
  output logic [N_UNITS-1:0]          recalled_pattern,
  output logic                        learning,
  output logic                        recalling,
  output logic                        busy,
  output logic                        learn_done,
  output logic                        recall_done
);

  localparam int c_IW          = $clog2(N_UNITS);
  localparam int c_AW          = WEIGHT_W + $clog2(N_UNITS) + 1;
  localparam int c_DW          = $clog2(DECAY_PERIOD + 1);
  localparam int c_WMAX        = 2 ** (WEIGHT_W - 1) - 1;
  localparam int c_LEARN_REARM = PEAK_THRESH - HYST;
  localparam int c_RECALL_REARM = TROUGH_THRESH + HYST;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(N_UNITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LEARN  = 2'd1,
    S_RECALL = 2'd2,
    S_DECAY  = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic signed [WEIGHT_W-1:0]  r_weights [N_UNITS][N_UNITS];
  logic [c_IW-1:0]             r_row;
  logic [c_IW-1:0]             r_col;
  logic [N_UNITS-1:0]          r_pattern;
  logic [N_UNITS-1:0]          r_result;
  logic signed [c_AW-1:0]      r_acc;
  logic                        r_learn_armed;
  logic                        r_recall_armed;
  logic [c_DW-1:0]             r_decay_cnt;
  logic [N_UNITS-1:0]          r_recalled;
  logic                        r_learning;
  logic                        r_recalling;
  logic                        r_learn_done;
  logic                        r_recall_done;

  logic                        w_learn_start;
  logic                        w_recall_start;
  logic                        w_decay_start;
  logic                        w_sweep_last;
  logic signed [WEIGHT_W-1:0]  w_cur;
  logic signed [WEIGHT_W-1:0]  w_learn_w;
  logic signed [WEIGHT_W-1:0]  w_decay_w;
  logic signed [c_AW-1:0]      w_sum;
  logic                        w_fire;
  logic [N_UNITS-1:0]          w_result_next;
  int                          w_learn_val;

  wire w_idle_tick = clk_en && (r_state == S_IDLE);

  assign w_learn_start  = w_idle_tick && r_learn_armed && learn_enable && pattern_valid &&
                          (|pattern_in) && (theta_x >= PEAK_THRESH);
  assign w_recall_start = w_idle_tick && !w_learn_start && r_recall_armed && pattern_valid &&
                          (|pattern_in) && (theta_x <= TROUGH_THRESH);
  assign w_decay_start  = w_idle_tick && !w_learn_start && !w_recall_start && decay_en &&
                          (r_decay_cnt >= c_DW'(DECAY_PERIOD));
  assign w_sweep_last   = (r_row == c_LAST) && (r_col == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_learn_start)       w_state_next = S_LEARN;
        else if (w_recall_start) w_state_next = S_RECALL;
        else if (w_decay_start)  w_state_next = S_DECAY;
      end
      default: if (w_sweep_last) w_state_next = S_IDLE;
    endcase
  end

  assign w_cur = r_weights[r_row][r_col];

  // Learn rule with symmetric saturation, so the most negative code is never produced
  always_comb begin
    w_learn_val = int'(w_cur);
    if (r_pattern[r_row] && r_pattern[r_col])       w_learn_val = int'(w_cur) + LR_POT;
    else if (r_pattern[r_row] != r_pattern[r_col])  w_learn_val = int'(w_cur) - LR_DEP;
    if (w_learn_val > c_WMAX)        w_learn_val = c_WMAX;
    else if (w_learn_val < -c_WMAX)  w_learn_val = -c_WMAX;
    w_learn_w = WEIGHT_W'(w_learn_val);
  end

  always_comb begin
    w_decay_w = w_cur;
    if (w_cur > 0)      w_decay_w = w_cur - WEIGHT_W'(1);
    else if (w_cur < 0) w_decay_w = w_cur + WEIGHT_W'(1);
  end

  assign w_sum  = r_acc + (r_pattern[r_col] ? c_AW'(w_cur) : '0);
  assign w_fire = (w_sum > RECALL_THRESH);

  always_comb begin
    w_result_next        = r_result;
    w_result_next[r_row] = r_pattern[r_row] | w_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_UNITS; i++)
        for (int j = 0; j < N_UNITS; j++)
          r_weights[i][j] <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_pattern      <= '0;
      r_result       <= '0;
      r_acc          <= '0;
      r_learn_armed  <= 1'b1;
      r_recall_armed <= 1'b1;
      r_decay_cnt    <= '0;
      r_recalled     <= '0;
      r_learning     <= 1'b0;
      r_recalling    <= 1'b0;
      r_learn_done   <= 1'b0;
      r_recall_done  <= 1'b0;
    end else begin
      r_learning    <= (w_state_next == S_LEARN);
      r_recalling   <= (w_state_next == S_RECALL);
      r_learn_done  <= (r_state == S_LEARN)  && w_sweep_last;
      r_recall_done <= (r_state == S_RECALL) && w_sweep_last;

      if (w_learn_start || w_recall_start) r_pattern <= pattern_in;

      if (clk_en) begin
        if (theta_x < c_LEARN_REARM) r_learn_armed <= 1'b1;
        else if (w_learn_start)      r_learn_armed <= 1'b0;
        if (theta_x > c_RECALL_REARM) r_recall_armed <= 1'b1;
        else if (w_recall_start)      r_recall_armed <= 1'b0;
      end

      // Counter saturates at the period so a decay blocked by LEARN/RECALL stays pending
      if (!decay_en)                                  r_decay_cnt <= '0;
      else if (w_decay_start)                         r_decay_cnt <= '0;
      else if (clk_en && r_decay_cnt < c_DW'(DECAY_PERIOD)) r_decay_cnt <= r_decay_cnt + c_DW'(1);

      if (r_state == S_IDLE || w_sweep_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_col == c_LAST) begin
        r_col <= '0;
        r_row <= r_row + c_IW'(1);
      end else begin
        r_col <= r_col + c_IW'(1);
      end

      if (r_state == S_LEARN && r_row != r_col) r_weights[r_row][r_col] <= w_learn_w;
      if (r_state == S_DECAY && r_row != r_col) r_weights[r_row][r_col] <= w_decay_w;

      if (r_state == S_RECALL) begin
        if (r_col == c_LAST) begin
          r_acc    <= '0;
          r_result <= w_result_next;
        end else begin
          r_acc <= w_sum;
        end
        if (w_sweep_last) r_recalled <= w_result_next;
      end else begin
        r_acc <= '0;
      end
    end
  end

  assign wt_rd_data = ((int'(wt_rd_row) < N_UNITS) && (int'(wt_rd_col) < N_UNITS)) ?
                      r_weights[wt_rd_row][wt_rd_col] : '0;

  assign recalled_pattern = r_recalled;
  assign learning         = r_learning;
  assign recalling        = r_recalling;
  assign busy             = (r_state != S_IDLE);
  assign learn_done       = r_learn_done;
  assign recall_done      = r_recall_done;

endmodule
`default_nettype wire
